// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RISC-V load/store unit: funct3 size codes and FSM states.
package riscv_lsu_pkg;

  typedef enum logic [2:0] {
    LDST_B  = 3'd0,
    LDST_H  = 3'd1,
    LDST_W  = 3'd2,
    LDST_BU = 3'd4,
    LDST_HU = 3'd5
  } ldst_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// Handshake: the memory finishes an access on the first rising edge where mem_req and mem_ready are both 1.
interface riscv_lsu_if;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  modport master (
    input  core_req, core_we, core_size, core_addr, core_wd, mem_rd, mem_ready,
    output core_rd, core_stall, misalign, mem_req, mem_we, mem_be, mem_addr, mem_wd
  );

  modport slave (
    output core_req, core_we, core_size, core_addr, core_wd, mem_rd, mem_ready,
    input  core_rd, core_stall, misalign, mem_req, mem_we, mem_be, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalign detection
// and load extraction with sign/zero extension.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic        req_we_i,
  input  logic [31:0] req_wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  always_comb begin
    be_o       = 4'b0000;
    wd_o       = req_wd_i;
    misalign_o = 1'b0;
    case (req_size_i)
      LDST_B: begin
        be_o = 4'b0001 << req_off_i;
        wd_o = {4{req_wd_i[7:0]}};
      end
      LDST_BU: begin
        be_o       = 4'b0001 << req_off_i;
        wd_o       = {4{req_wd_i[7:0]}};
        misalign_o = req_we_i;
      end
      LDST_H: begin
        be_o       = 4'b0011 << req_off_i;
        wd_o       = {2{req_wd_i[15:0]}};
        misalign_o = req_off_i[0];
      end
      LDST_HU: begin
        be_o       = 4'b0011 << req_off_i;
        wd_o       = {2{req_wd_i[15:0]}};
        misalign_o = req_off_i[0] | req_we_i;
      end
      LDST_W: begin
        be_o       = 4'b1111;
        misalign_o = (req_off_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from there.
  always_comb begin
    ld_shift  = ld_word_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_word_i;
    case (ld_size_i)
      LDST_B:  ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      LDST_BU: ld_data_o = {24'h000000, ld_shift[7:0]};
      LDST_H:  ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      LDST_HU: ld_data_o = {16'h0000, ld_shift[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding data-memory access, IDLE -> (WAIT)* -> DONE -> IDLE.
// The core is stalled while the request is on the bus; the load result is valid in DONE.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output lsu_state_e  state_o
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;

  logic        accept;
  logic        in_wait;
  logic        ld_we;
  logic [2:0]  ld_size;
  logic [1:0]  ld_off;
  logic [3:0]  al_be;
  logic [31:0] al_wd;
  logic        al_misalign;
  logic [31:0] al_ld_data;

  lsu_align u_align (
    .req_size_i (core_size_i),
    .req_off_i  (core_addr_i[1:0]),
    .req_we_i   (core_we_i),
    .req_wd_i   (core_wd_i),
    .be_o       (al_be),
    .wd_o       (al_wd),
    .misalign_o (al_misalign),
    .ld_size_i  (ld_size),
    .ld_off_i   (ld_off),
    .ld_word_i  (mem_rd_i),
    .ld_data_o  (al_ld_data)
  );

  always_comb begin
    in_wait = (state_q == S_WAIT);
    accept  = (state_q == S_IDLE) && core_req_i && !al_misalign;
    // Gating with reset drops the bus request the instant reset asserts.
    mem_req_o    = rst_i && (accept || in_wait);
    core_stall_o = mem_req_o;
    misalign_o   = (state_q == S_IDLE) && core_req_i && al_misalign;
    mem_we_o     = in_wait ? we_q : core_we_i;
    mem_be_o     = in_wait ? be_q : al_be;
    mem_wd_o     = in_wait ? wd_q : al_wd;
    mem_addr_o   = in_wait ? {waddr_q, 2'b00} : {core_addr_i[31:2], 2'b00};
    ld_we        = in_wait ? we_q : core_we_i;
    ld_size      = in_wait ? size_q : core_size_i;
    ld_off       = in_wait ? off_q : core_addr_i[1:0];
    core_rd_o    = rd_q;
    state_o      = state_q;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = core_we_i;
          size_d  = core_size_i;
          off_d   = core_addr_i[1:0];
          waddr_d = core_addr_i[31:2];
          be_d    = al_be;
          wd_d    = al_wd;
          state_d = mem_ready_i ? S_DONE : S_WAIT;
          if (mem_ready_i && !ld_we) rd_d = al_ld_data;
        end
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          state_d = S_DONE;
          if (!ld_we) rd_d = al_ld_data;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      waddr_q <= 30'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed scenarios plus random accesses against a byte-lane reference model.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  lsu_state_e state_dbg;
  riscv_lsu_if bus ();

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .core_req_i   (bus.core_req),
    .core_we_i    (bus.core_we),
    .core_size_i  (bus.core_size),
    .core_addr_i  (bus.core_addr),
    .core_wd_i    (bus.core_wd),
    .core_rd_o    (bus.core_rd),
    .core_stall_o (bus.core_stall),
    .misalign_o   (bus.misalign),
    .mem_req_o    (bus.mem_req),
    .mem_we_o     (bus.mem_we),
    .mem_be_o     (bus.mem_be),
    .mem_addr_o   (bus.mem_addr),
    .mem_wd_o     (bus.mem_wd),
    .mem_rd_i     (bus.mem_rd),
    .mem_ready_i  (bus.mem_ready),
    .state_o      (state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: an access touches n = 1, 2 or 4 consecutive bytes starting at the address.
  function automatic int nbytes(input logic [2:0] sz);
    if (sz == 3'd0 || sz == 3'd4) return 1;
    if (sz == 3'd1 || sz == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic model_bad(input logic we, input logic [2:0] sz, input logic [31:0] a);
    if (!(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (we && sz >= 3'd4) return 1'b1;
    return (int'(a % 4) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(sz)) - 1) << int'(a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] word);
    longint v, mask;
    int n;
    n = nbytes(sz);
    if (n == 4) return word;
    mask = (64'd1 << (8 * n)) - 1;
    v = (longint'(word) >> (8 * int'(a % 4))) & mask;
    if (sz < 3'd4 && v[8*n-1]) v = v | (~mask);
    return v[31:0];
  endfunction

  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word, input int delay,
                        input string nm);
    logic        bad;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    int          stalls;
    bad   = model_bad(we, sz, addr);
    ebe   = model_be(sz, addr);
    ewd   = model_wd(sz, wd);
    eaddr = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    bus.core_req  = 1'b1;
    bus.core_we   = we;
    bus.core_size = sz;
    bus.core_addr = addr;
    bus.core_wd   = wd;
    bus.mem_ready = (delay == 0);
    bus.mem_rd    = (delay == 0) ? word : $urandom;
    @(negedge clk);
    chk({nm, ".misalign"}, 32'(bus.misalign), 32'(bad));
    if (bad) begin
      chk({nm, ".mis_req"}, 32'(bus.mem_req), 32'd0);
      chk({nm, ".mis_stall"}, 32'(bus.core_stall), 32'd0);
      @(posedge clk); #1;
      bus.core_req  = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk({nm, ".mis_state"}, 32'(state_dbg), 32'(S_IDLE));
      chk({nm, ".mis_rd"}, bus.core_rd, last_rd);
      return;
    end
    if (!we) exp_q.push_back(model_ld(sz, addr, word));
    stalls = 0;
    chk({nm, ".req"}, 32'(bus.mem_req), 32'd1);
    chk({nm, ".addr"}, bus.mem_addr, eaddr);
    chk({nm, ".be"}, 32'(bus.mem_be), 32'(ebe));
    chk({nm, ".we"}, 32'(bus.mem_we), 32'(we));
    if (we) chk({nm, ".wd"}, bus.mem_wd, ewd);
    stalls += int'(bus.core_stall);
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk); #1;
      bus.core_req  = 1'($urandom_range(0, 1));
      bus.core_we   = 1'($urandom_range(0, 1));
      bus.core_size = 3'($urandom_range(0, 7));
      bus.core_addr = $urandom;
      bus.core_wd   = $urandom;
      bus.mem_ready = (k == delay);
      bus.mem_rd    = (k == delay) ? word : $urandom;
      @(negedge clk);
      chk({nm, ".hold_req"}, 32'(bus.mem_req), 32'd1);
      chk({nm, ".hold_addr"}, bus.mem_addr, eaddr);
      chk({nm, ".hold_be"}, 32'(bus.mem_be), 32'(ebe));
      chk({nm, ".hold_we"}, 32'(bus.mem_we), 32'(we));
      if (we) chk({nm, ".hold_wd"}, bus.mem_wd, ewd);
      chk({nm, ".wait_mis"}, 32'(bus.misalign), 32'd0);
      chk({nm, ".wait_rd"}, bus.core_rd, last_rd);
      stalls += int'(bus.core_stall);
    end
    // A legal request presented in DONE must be ignored.
    @(posedge clk); #1;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_size = 3'd2;
    bus.core_addr = 32'h0000_0040;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rd    = $urandom;
    @(negedge clk);
    chk({nm, ".done_stall"}, 32'(bus.core_stall), 32'd0);
    chk({nm, ".done_req"}, 32'(bus.mem_req), 32'd0);
    chk({nm, ".stall_cycles"}, 32'(stalls), 32'(delay + 1));
    if (!we) last_rd = exp_q.pop_front();
    chk({nm, ".done_rd"}, bus.core_rd, last_rd);
    @(posedge clk); #1;
    bus.core_req  = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({nm, ".idle_state"}, 32'(state_dbg), 32'(S_IDLE));
    chk({nm, ".idle_req"}, 32'(bus.mem_req), 32'd0);
    chk({nm, ".idle_rd"}, bus.core_rd, last_rd);
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  size_tbl [10];
    logic [2:0]  sz;
    logic [31:0] a;
    size_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    last_rd = 32'd0;

    // Clock/reset
    rst_n         = 1'b0;
    bus.core_req  = 1'b0;
    bus.core_we   = 1'b0;
    bus.core_size = 3'd0;
    bus.core_addr = 32'd0;
    bus.core_wd   = 32'd0;
    bus.mem_rd    = 32'd0;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst.req", 32'(bus.mem_req), 32'd0);
    chk("rst.stall", 32'(bus.core_stall), 32'd0);
    chk("rst.rd", bus.core_rd, 32'd0);
    chk("rst.state", 32'(state_dbg), 32'(S_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    access(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0, "sw");
    access(1'b0, 3'd0, 32'h0000_0203, 32'd0, 32'h8012_3456, 3, "lb");
    chk("lb.value", bus.core_rd, 32'hFFFF_FF80);
    access(1'b0, 3'd5, 32'h0000_0202, 32'd0, 32'hABCD_1234, 1, "lhu");
    chk("lhu.value", bus.core_rd, 32'h0000_ABCD);
    access(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00A5, 32'd0, 2, "sb");
    access(1'b0, 3'd2, 32'h0000_0102, 32'd0, 32'h1111_1111, 0, "lw_mis");
    access(1'b1, 3'd4, 32'h0000_0104, 32'h5555_5555, 32'd0, 0, "sbu_bad");
    access(1'b0, 3'd1, 32'h0000_0106, 32'd0, 32'h8001_7FFF, 0, "lh_hi");

    // Reset asserted in the middle of WAIT
    @(posedge clk); #1;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_size = 3'd2;
    bus.core_addr = 32'h0000_0300;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rstw.req_before", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #2;
    chk("rstw.in_wait", 32'(state_dbg), 32'(S_WAIT));
    rst_n = 1'b0;
    #1;
    chk("rstw.req", 32'(bus.mem_req), 32'd0);
    chk("rstw.stall", 32'(bus.core_stall), 32'd0);
    chk("rstw.rd", bus.core_rd, 32'd0);
    chk("rstw.state", 32'(state_dbg), 32'(S_IDLE));
    last_rd = 32'd0;
    bus.core_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'h1234_5678, 1, "lw_after_rst");

    // Random accesses
    for (int i = 0; i < 40; i++) begin
      sz = size_tbl[$urandom_range(0, 9)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom, $urandom_range(0, 3), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
